cmac_block_fetcher: RTL and testbench
=====================================

# cmac_block_fetcher

Parametrised message-block fetcher between the message BRAM and the AES-CMAC core. On `start` it latches a bit length and base address, reads ceil(len/BLOCK_W) blocks from a synchronous-read RAM with configurable read latency, applies CMAC 10* padding to a partial final block, and delivers blocks over a valid/ready stream. Each block carries a `last` flag and a `complete` flag, so the core can select subkey K1 (full final block) or K2 (padded). A prefetch FIFO with credit control absorbs core backpressure without losing in-flight RAM data.

## Interface
Parameters:
- `BLOCK_W`, 128, block width in bits (power of two)
- `ADDR_W`, 9, RAM address width
- `LEN_W`, 32, width of the message-length input (bits)
- `RAM_LAT`, 1, RAM read latency in cycles (≥1)
- `FIFO_DEPTH`, 4, prefetch FIFO entries (≥ RAM_LAT+1, power of two)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  request pulse; accepted only when `busy`=0
- `len`  in  LEN_W  message length in bits, sampled with `start`
- `base_addr`  in  ADDR_W  RAM address of first block, sampled with `start`
- `busy`  out  1  high from the cycle after an accepted `start` until `done`
- `ram_en`  out  1  read strobe, registered
- `ram_addr`  out  ADDR_W  read address, registered
- `ram_dout`  in  BLOCK_W  read data, valid RAM_LAT cycles after `ram_en`
- `blk_data`  out  BLOCK_W  block; bit BLOCK_W-1 is the first message bit
- `blk_valid`  out  1  block available
- `blk_ready`  in  1  consumer accepts when `blk_valid`&`blk_ready`
- `blk_last`  out  1  qualifies the final block
- `blk_complete`  out  1  with `blk_last`: 1 = final block full, 0 = padded
- `done`  out  1  one-cycle pulse after the final block handshake

## Operation
- States: IDLE, FETCH, DRAIN. IDLE→FETCH on `start` (len>0); IDLE→DRAIN on `start` with len=0; FETCH→DRAIN when all reads issued; DRAIN→IDLE on final handshake (`done` pulses the following cycle).
- nblk = (len+BLOCK_W-1)/BLOCK_W, computed in LEN_W+1 bits; rem = len mod BLOCK_W.
- Read i (0..nblk-1) uses address (base_addr+i) mod 2^ADDR_W; wraps silently.
- Credit rule: issue read only if fifo_count + outstanding_reads < FIFO_DEPTH. Every issued read is written into the FIFO exactly RAM_LAT cycles later, unconditionally.
- Padding on the block with index nblk-1 when rem≠0: keep top rem bits, set bit BLOCK_W-1-rem to 1, clear lower bits; `blk_complete`=0. When rem=0, data is passed unmodified; `blk_complete`=1.
- len=0: no RAM read; emit one block 1 followed by BLOCK_W-1 zeros, with `blk_last`=1, `blk_complete`=0.
- `start` while `busy`=1 is ignored; latched len/base are unaffected.
- Tag/sideband (last, complete) travels with the FIFO entry, not computed at output.

## Timing
- Reset (sync): all outputs 0; FIFO, counters, and in-flight read pipeline cleared. Data returned after reset from reads issued before reset is discarded.
- `start` sampled at edge of cycle 0; `busy`=1 and first `ram_en` in cycle 1.
- `ram_dout` for a read in cycle t is captured at end of cycle t+RAM_LAT; the block appears with `blk_valid`=1 in cycle t+RAM_LAT+1 (first block: cycle RAM_LAT+2).
- With `blk_ready` held 1: one block per cycle sustained; nblk blocks span cycles RAM_LAT+2 … RAM_LAT+nblk+1.
- `blk_data`/`blk_last`/`blk_complete` stay stable while `blk_valid`=1 and `blk_ready`=0.
- `done` pulses in the cycle after the last handshake; `busy` is 0 in that same cycle; a new `start` is accepted in that cycle.
- FIFO full and empty with simultaneous push and pop: count unchanged, no loss.

## Test plan
- len=0, base=5 → no `ram_en`; one block 0x8000…0000, last=1, complete=0; `done` one cycle after handshake.
- len=34176, base=0, ready=1, RAM_LAT=1 → 267 reads at addresses 0..266; blocks equal mem[0..266] in order; only the 267th has last=1, complete=1; first valid in cycle 3.
- len=200, base=0 → 2 blocks; block 1 = top 72 bits of mem[1], bit 55 = 1, bits 54..0 = 0, last=1, complete=0.
- Wrap: ADDR_W=9, base=510, len=512 → reads 510, 511, 0, 1; last block complete=1.
- Backpressure with RAM_LAT=3: `blk_ready` low 10 cycles, then random → `ram_en` stalls at FIFO_DEPTH credits; no drop/duplicate; output order and data match memory.
- Reset after 5 blocks of a 267-block transfer → next cycle all outputs 0; stale read data not emitted; a new `start` (len=128) yields exactly one correct block. `start` during `busy` has no effect.

Source files
------------

// File: rtl/cmac_block_fetcher.sv
// Message-block fetcher for the AES-CMAC core: credit-controlled RAM reads,
// prefetch FIFO with registered head, and 10* padding of a partial final block.
module cmac_block_fetcher #(
  parameter int unsigned BLOCK_W    = 128,
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned LEN_W      = 32,
  parameter int unsigned RAM_LAT    = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  input  logic [ADDR_W-1:0]  base_addr,
  output logic               busy,
  output logic               ram_en,
  output logic [ADDR_W-1:0]  ram_addr,
  input  logic [BLOCK_W-1:0] ram_dout,
  output logic [BLOCK_W-1:0] blk_data,
  output logic               blk_valid,
  input  logic               blk_ready,
  output logic               blk_last,
  output logic               blk_complete,
  output logic               done
);

  localparam int unsigned LOG_W = $clog2(BLOCK_W);
  localparam int unsigned CNT_W = LEN_W + 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + RAM_LAT + 2) + 1;
  localparam logic [BLOCK_W-1:0] ONES = '1;
  localparam logic [BLOCK_W-1:0] MSB  = {1'b1, {(BLOCK_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  typedef struct packed {
    logic [BLOCK_W-1:0] data;
    logic               last;
    logic               complete;
  } entry_t;

  state_t              r_state, w_state_nxt;
  logic                r_busy, r_done;
  logic                r_ram_en, r_ram_last;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [CNT_W-1:0]    r_nblk, r_rd_cnt;
  logic [LOG_W-1:0]    r_rem;
  logic [RAM_LAT-1:0]  r_pipe_v, r_pipe_last;
  logic                r_zero_inj;
  entry_t              r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]      r_bcnt;
  entry_t              r_out;
  logic                r_out_valid;

  logic                w_issue, w_issue_last;
  logic [ADDR_W-1:0]   w_issue_addr;
  logic [CNT_W-1:0]    w_nblk_in;
  logic [OCC_W-1:0]    w_occ;
  logic                w_pop, w_load, w_bempty, w_from_b, w_bypass, w_wr, w_push, w_final;
  logic [BLOCK_W-1:0]  w_pad;
  entry_t              w_push_entry;

  assign w_nblk_in = (CNT_W'(len) + CNT_W'(BLOCK_W - 1)) >> LOG_W;
  assign w_pop     = r_out_valid & blk_ready;
  assign w_final   = w_pop & r_out.last;
  assign w_load    = ~r_out_valid | w_pop;
  assign w_bempty  = (r_bcnt == '0);
  assign w_from_b  = w_load & ~w_bempty;
  assign w_push    = r_pipe_v[RAM_LAT-1] | r_zero_inj;
  assign w_bypass  = w_load & w_bempty & w_push;
  assign w_wr      = w_push & ~w_bypass;

  // Projected occupancy next cycle: queued entries + every read still in flight.
  always_comb begin
    w_occ = OCC_W'(r_out_valid) + OCC_W'(r_bcnt) + OCC_W'(r_ram_en) - OCC_W'(w_pop);
    for (int i = 0; i < int'(RAM_LAT); i++) w_occ = w_occ + OCC_W'(r_pipe_v[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_issue      = 1'b0;
    w_issue_last = 1'b0;
    w_issue_addr = r_ram_addr;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (len == '0) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_state_nxt  = S_FETCH;
            w_issue      = 1'b1;
            w_issue_addr = base_addr;
            w_issue_last = (w_nblk_in == CNT_W'(1));
          end
        end
      end
      S_FETCH: begin
        if (r_rd_cnt == r_nblk) begin
          w_state_nxt = S_DRAIN;
        end else if (w_occ < OCC_W'(FIFO_DEPTH)) begin
          w_issue      = 1'b1;
          w_issue_addr = r_ram_addr + ADDR_W'(1);
          w_issue_last = (r_rd_cnt == r_nblk - CNT_W'(1));
        end
      end
      S_DRAIN: begin
        if (w_final) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sideband is resolved when the read data lands, so it is stored with the entry.
  always_comb begin
    w_pad        = (ram_dout & ~(ONES >> r_rem)) | (MSB >> r_rem);
    w_push_entry = '0;
    if (r_zero_inj) begin
      w_push_entry.data     = MSB;
      w_push_entry.last     = 1'b1;
      w_push_entry.complete = 1'b0;
    end else begin
      w_push_entry.last     = r_pipe_last[RAM_LAT-1];
      w_push_entry.complete = r_pipe_last[RAM_LAT-1] & (r_rem == '0);
      w_push_entry.data     = (r_pipe_last[RAM_LAT-1] && r_rem != '0) ? w_pad : ram_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_last  <= 1'b0;
      r_ram_addr  <= '0;
      r_nblk      <= '0;
      r_rd_cnt    <= '0;
      r_rem       <= '0;
      r_pipe_v    <= '0;
      r_pipe_last <= '0;
      r_zero_inj  <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_bcnt      <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= (r_state == S_DRAIN) & w_final;
      r_ram_en   <= w_issue;
      r_ram_last <= w_issue_last;
      if (w_issue) r_ram_addr <= w_issue_addr;
      r_zero_inj <= (r_state == S_IDLE) & start & (len == '0);
      if (r_state == S_IDLE && start) begin
        r_nblk <= w_nblk_in;
        r_rem  <= len[LOG_W-1:0];
      end
      if (r_state == S_IDLE) r_rd_cnt <= CNT_W'(w_issue);
      else if (w_issue)      r_rd_cnt <= r_rd_cnt + CNT_W'(1);

      r_pipe_v[0]    <= r_ram_en;
      r_pipe_last[0] <= r_ram_last;
      for (int i = 1; i < int'(RAM_LAT); i++) begin
        r_pipe_v[i]    <= r_pipe_v[i-1];
        r_pipe_last[i] <= r_pipe_last[i-1];
      end

      // Head register refills from the backing store first, else bypasses the push.
      if (w_load) begin
        if (!w_bempty)   r_out <= r_mem[r_rd_ptr];
        else if (w_push) r_out <= w_push_entry;
        r_out_valid <= ~w_bempty | w_push;
      end
      if (w_from_b) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_wr)     r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_bcnt <= r_bcnt + (PTR_W+1)'(w_wr) - (PTR_W+1)'(w_from_b);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_push_entry;
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign ram_en       = r_ram_en;
  assign ram_addr     = r_ram_addr;
  assign blk_valid    = r_out_valid;
  assign blk_data     = r_out.data;
  assign blk_last     = r_out.last;
  assign blk_complete = r_out.complete;

endmodule

// File: tb/tb_cmac_block_fetcher.sv
// Directed bench for cmac_block_fetcher: one instance at RAM_LAT=1, one at RAM_LAT=3.
module tb_cmac_block_fetcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic         a_start, a_busy, a_ram_en, a_blk_valid, a_blk_ready, a_blk_last, a_blk_complete, a_done;
  logic [31:0]  a_len;
  logic [8:0]   a_base, a_ram_addr;
  logic [127:0] a_ram_dout, a_blk_data;
  logic         b_start, b_busy, b_ram_en, b_blk_valid, b_blk_ready, b_blk_last, b_blk_complete, b_done;
  logic [31:0]  b_len;
  logic [8:0]   b_base, b_ram_addr;
  logic [127:0] b_ram_dout, b_blk_data;

  cmac_block_fetcher #(.BLOCK_W(128), .ADDR_W(9), .LEN_W(32), .RAM_LAT(1), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .reset(reset), .start(a_start), .len(a_len), .base_addr(a_base), .busy(a_busy),
    .ram_en(a_ram_en), .ram_addr(a_ram_addr), .ram_dout(a_ram_dout), .blk_data(a_blk_data),
    .blk_valid(a_blk_valid), .blk_ready(a_blk_ready), .blk_last(a_blk_last),
    .blk_complete(a_blk_complete), .done(a_done));

  cmac_block_fetcher #(.BLOCK_W(128), .ADDR_W(9), .LEN_W(32), .RAM_LAT(3), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .reset(reset), .start(b_start), .len(b_len), .base_addr(b_base), .busy(b_busy),
    .ram_en(b_ram_en), .ram_addr(b_ram_addr), .ram_dout(b_ram_dout), .blk_data(b_blk_data),
    .blk_valid(b_blk_valid), .blk_ready(b_blk_ready), .blk_last(b_blk_last),
    .blk_complete(b_blk_complete), .done(b_done));

  function automatic logic [127:0] mem_val(input logic [8:0] a);
    logic [31:0] x;
    x = 32'(a);
    return {x * 32'h9E3779B1, x ^ 32'hCAFEBABE, (x + 32'd7) * 32'h85EBCA6B, 32'hF00D0000 | x};
  endfunction

  // RAM models; idle cycles return junk so only correctly timed captures are right.
  logic [127:0] a_rp;
  logic [127:0] b_rp [3];
  always @(posedge clk) begin
    a_rp    <= a_ram_en ? mem_val(a_ram_addr) : {4{32'hDEADBEEF}};
    b_rp[0] <= b_ram_en ? mem_val(b_ram_addr) : {4{32'hDEADBEEF}};
    b_rp[1] <= b_rp[0];
    b_rp[2] <= b_rp[1];
  end
  assign a_ram_dout = a_rp;
  assign b_ram_dout = b_rp[2];

  logic [127:0] a_dq[$], b_dq[$];
  bit           a_lq[$], a_cq[$], b_lq[$], b_cq[$];
  int           a_hcyc[$], a_acyc[$], a_dcyc[$], b_dcyc[$];
  logic [8:0]   a_aq[$], b_aq[$];
  int           a_busy_at_done = 0;
  int           b_unstable = 0, b_issued = 0, b_popped = 0, b_max_inflight = 0;
  bit           b_hold = 1'b0;
  logic [129:0] b_prev;

  always @(negedge clk) begin
    if (a_ram_en) begin a_aq.push_back(a_ram_addr); a_acyc.push_back(cyc); end
    if (a_blk_valid && a_blk_ready) begin
      a_dq.push_back(a_blk_data); a_lq.push_back(a_blk_last); a_cq.push_back(a_blk_complete);
      a_hcyc.push_back(cyc);
    end
    if (a_done) begin a_dcyc.push_back(cyc); if (a_busy) a_busy_at_done++; end

    if (b_ram_en) begin b_aq.push_back(b_ram_addr); b_issued++; end
    if (b_issued - b_popped > b_max_inflight) b_max_inflight = b_issued - b_popped;
    if (b_hold && (!b_blk_valid || {b_blk_data, b_blk_last, b_blk_complete} !== b_prev)) b_unstable++;
    if (b_blk_valid && b_blk_ready) begin
      b_dq.push_back(b_blk_data); b_lq.push_back(b_blk_last); b_cq.push_back(b_blk_complete);
      b_popped++;
    end
    if (b_done) b_dcyc.push_back(cyc);
    b_hold = b_blk_valid && !b_blk_ready;
    b_prev = {b_blk_data, b_blk_last, b_blk_complete};
  end

  task automatic clr_a();
    a_dq.delete(); a_lq.delete(); a_cq.delete(); a_hcyc.delete();
    a_aq.delete(); a_acyc.delete(); a_dcyc.delete(); a_busy_at_done = 0;
  endtask

  task automatic start_a(input logic [31:0] l, input logic [8:0] b, output int t0);
    @(posedge clk); #1;
    a_start = 1'b1; a_len = l; a_base = b; t0 = cyc;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  task automatic wait_a_done(input int n, input int budget, input string nm);
    int k;
    k = 0;
    while (a_dcyc.size() < n && k < budget) begin @(posedge clk); k++; end
    #1;
    checks++;
    if (a_dcyc.size() < n) begin
      failures++;
      $display("FAIL %s_timeout: done pulses=%0d required=%0d", nm, a_dcyc.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_start = 1'b0; a_len = '0; a_base = '0; a_blk_ready = 1'b1;
    b_start = 1'b0; b_len = '0; b_base = '0; b_blk_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a_busy, a_ram_en, a_ram_addr, a_blk_valid, a_blk_data, a_blk_last, a_blk_complete, a_done} !== '0) begin
      failures++; $display("FAIL reset_a: busy=%b valid=%b done=%b ram_en=%b, required all 0", a_busy, a_blk_valid, a_done, a_ram_en);
    end
    checks++;
    if ({b_busy, b_ram_en, b_ram_addr, b_blk_valid, b_blk_data, b_blk_last, b_blk_complete, b_done} !== '0) begin
      failures++; $display("FAIL reset_b: busy=%b valid=%b done=%b ram_en=%b, required all 0", b_busy, b_blk_valid, b_done, b_ram_en);
    end
    reset = 1'b0;
  endtask

  task automatic test_zero_len();
    int t0;
    logic [127:0] exp;
    exp = '0; exp[127] = 1'b1;
    clr_a();
    start_a(32'd0, 9'd5, t0);
    wait_a_done(1, 20, "zero");
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (a_aq.size() != 0) begin failures++; $display("FAIL zero_reads: reads=%0d required=0", a_aq.size()); end
    checks++;
    if (a_dq.size() != 1) begin failures++; $display("FAIL zero_count: blocks=%0d required=1", a_dq.size()); end
    if (a_dq.size() == 1) begin
      checks++;
      if ({a_dq[0], a_lq[0], a_cq[0]} !== {exp, 1'b1, 1'b0}) begin
        failures++; $display("FAIL zero_block: got %h last=%b cmp=%b required %h last=1 cmp=0", a_dq[0], a_lq[0], a_cq[0], exp);
      end
      checks++;
      if (a_dcyc.size() != 1 || a_dcyc[0] != a_hcyc[0] + 1) begin
        failures++; $display("FAIL zero_done_timing: done pulses=%0d, required one pulse at handshake cycle+1", a_dcyc.size());
      end
    end
    checks++;
    if (a_busy_at_done != 0) begin failures++; $display("FAIL zero_busy_at_done: got %0d required 0", a_busy_at_done); end
  endtask

  task automatic test_long();
    int t0, n;
    clr_a();
    start_a(32'd34176, 9'd0, t0);
    wait_a_done(1, 400, "long");
    checks++;
    if (a_aq.size() != 267) begin failures++; $display("FAIL long_reads: got %0d required 267", a_aq.size()); end
    checks++;
    if (a_dq.size() != 267) begin failures++; $display("FAIL long_blocks: got %0d required 267", a_dq.size()); end
    n = (a_aq.size() < 267) ? a_aq.size() : 267;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (a_aq[i] !== 9'(i)) begin failures++; $display("FAIL long_addr[%0d]: got %0d required %0d", i, a_aq[i], i); end
    end
    n = (a_dq.size() < 267) ? a_dq.size() : 267;
    for (int i = 0; i < n; i++) begin
      checks++;
      if ({a_dq[i], a_lq[i]} !== {mem_val(9'(i)), 1'(i == 266)}) begin
        failures++; $display("FAIL long_blk[%0d]: got %h last=%b required %h last=%b", i, a_dq[i], a_lq[i], mem_val(9'(i)), i == 266);
      end
    end
    if (a_dq.size() == 267) begin
      checks++;
      if (a_cq[266] !== 1'b1) begin failures++; $display("FAIL long_complete: got %b required 1", a_cq[266]); end
      checks++;
      if (a_acyc[0] != t0 + 1 || a_hcyc[0] != t0 + 3 || a_hcyc[266] != t0 + 269) begin
        failures++; $display("FAIL long_timing: ram_en@%0d first@%0d last@%0d required 1/3/269", a_acyc[0] - t0, a_hcyc[0] - t0, a_hcyc[266] - t0);
      end
      checks++;
      if (a_dcyc[0] != t0 + 270) begin failures++; $display("FAIL long_done: got cycle %0d required 270", a_dcyc[0] - t0); end
    end
  endtask

  task automatic test_pad_and_busy_start();
    int t0;
    logic [127:0] m1, exp;
    m1 = mem_val(9'd1);
    exp = {m1[127:56], 1'b1, 55'b0};
    clr_a();
    start_a(32'd200, 9'd0, t0);
    a_start = 1'b1; a_len = 32'd0; a_base = 9'd99;
    @(posedge clk); #1;
    a_start = 1'b0;
    wait_a_done(1, 30, "pad");
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (a_aq.size() != 2 || a_aq[0] !== 9'd0 || a_aq[1] !== 9'd1) begin
      failures++; $display("FAIL pad_reads: got %0d reads, required addresses 0,1", a_aq.size());
    end
    checks++;
    if (a_dq.size() != 2 || a_dcyc.size() != 1) begin
      failures++; $display("FAIL busy_start_ignored: blocks=%0d dones=%0d required 2 and 1", a_dq.size(), a_dcyc.size());
    end
    if (a_dq.size() >= 2) begin
      checks++;
      if ({a_dq[0], a_lq[0]} !== {mem_val(9'd0), 1'b0}) begin
        failures++; $display("FAIL pad_blk0: got %h last=%b required %h last=0", a_dq[0], a_lq[0], mem_val(9'd0));
      end
      checks++;
      if ({a_dq[1], a_lq[1], a_cq[1]} !== {exp, 1'b1, 1'b0}) begin
        failures++; $display("FAIL pad_blk1: got %h last=%b cmp=%b required %h last=1 cmp=0", a_dq[1], a_lq[1], a_cq[1], exp);
      end
    end
  endtask

  task automatic test_wrap();
    int t0;
    logic [8:0] ea [4];
    ea[0] = 9'd510; ea[1] = 9'd511; ea[2] = 9'd0; ea[3] = 9'd1;
    clr_a();
    start_a(32'd512, 9'd510, t0);
    wait_a_done(1, 30, "wrap");
    checks++;
    if (a_aq.size() != 4 || a_dq.size() != 4) begin
      failures++; $display("FAIL wrap_count: reads=%0d blocks=%0d required 4 and 4", a_aq.size(), a_dq.size());
    end
    if (a_aq.size() == 4 && a_dq.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ({a_aq[i], a_dq[i], a_lq[i]} !== {ea[i], mem_val(ea[i]), 1'(i == 3)}) begin
          failures++; $display("FAIL wrap_blk[%0d]: addr %0d data %h last=%b required addr %0d data %h", i, a_aq[i], a_dq[i], a_lq[i], ea[i], mem_val(ea[i]));
        end
      end
      checks++;
      if (a_cq[3] !== 1'b1) begin failures++; $display("FAIL wrap_complete: got %b required 1", a_cq[3]); end
    end
  endtask

  task automatic test_back_to_back();
    int t0, k;
    clr_a();
    start_a(32'd128, 9'd3, t0);
    k = 0;
    do begin @(negedge clk); k++; end while (!a_done && k < 20);
    a_start = 1'b1; a_len = 32'd256; a_base = 9'd9;
    @(posedge clk); #1;
    a_start = 1'b0;
    checks++;
    if (a_busy !== 1'b1) begin failures++; $display("FAIL b2b_busy: got %b required 1", a_busy); end
    wait_a_done(2, 30, "b2b");
    checks++;
    if (a_dq.size() != 3) begin failures++; $display("FAIL b2b_count: got %0d required 3", a_dq.size()); end
    if (a_dq.size() == 3) begin
      checks++;
      if ({a_dq[0], a_dq[1], a_dq[2], a_lq[0], a_lq[1], a_lq[2]} !==
          {mem_val(9'd3), mem_val(9'd9), mem_val(9'd10), 1'b1, 1'b0, 1'b1}) begin
        failures++; $display("FAIL b2b_data: got %h %h %h lasts %b%b%b required mem[3] mem[9] mem[10] lasts 101", a_dq[0], a_dq[1], a_dq[2], a_lq[0], a_lq[1], a_lq[2]);
      end
    end
  endtask

  task automatic test_backpressure();
    int k;
    b_dq.delete(); b_lq.delete(); b_cq.delete(); b_aq.delete(); b_dcyc.delete();
    b_issued = 0; b_popped = 0; b_max_inflight = 0; b_unstable = 0;
    @(posedge clk); #1;
    b_blk_ready = 1'b0;
    b_start = 1'b1; b_len = 32'd2560; b_base = 9'd100;
    @(posedge clk); #1;
    b_start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++;
    if (b_aq.size() != 4 || b_dq.size() != 0) begin
      failures++; $display("FAIL bp_stall: reads=%0d blocks=%0d required 4 and 0", b_aq.size(), b_dq.size());
    end
    k = 0;
    while (b_dcyc.size() == 0 && k < 400) begin
      @(posedge clk); #1;
      b_blk_ready = 1'($urandom_range(0, 1));
      k++;
    end
    b_blk_ready = 1'b1;
    checks++;
    if (b_dcyc.size() == 0) begin failures++; $display("FAIL bp_timeout: no done, blocks=%0d required 20", b_dq.size()); end
    checks++;
    if (b_aq.size() != 20 || b_dq.size() != 20) begin
      failures++; $display("FAIL bp_count: reads=%0d blocks=%0d required 20 and 20", b_aq.size(), b_dq.size());
    end
    if (b_aq.size() == 20 && b_dq.size() == 20) begin
      for (int i = 0; i < 20; i++) begin
        checks++;
        if ({b_aq[i], b_dq[i], b_lq[i]} !== {9'(100 + i), mem_val(9'(100 + i)), 1'(i == 19)}) begin
          failures++; $display("FAIL bp_blk[%0d]: addr %0d data %h last=%b required addr %0d data %h", i, b_aq[i], b_dq[i], b_lq[i], 100 + i, mem_val(9'(100 + i)));
        end
      end
      checks++;
      if (b_cq[19] !== 1'b1) begin failures++; $display("FAIL bp_complete: got %b required 1", b_cq[19]); end
    end
    checks++;
    if (b_max_inflight != 4) begin failures++; $display("FAIL bp_credits: max in flight %0d required 4", b_max_inflight); end
    checks++;
    if (b_unstable != 0) begin failures++; $display("FAIL bp_stable: %0d unstable stalled cycles required 0", b_unstable); end
  endtask

  task automatic test_reset_mid();
    int t0, k;
    clr_a();
    start_a(32'd34176, 9'd0, t0);
    k = 0;
    while (a_dq.size() < 5 && k < 50) begin @(posedge clk); k++; end
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({a_busy, a_ram_en, a_ram_addr, a_blk_valid, a_blk_data, a_blk_last, a_blk_complete, a_done} !== '0) begin
      failures++; $display("FAIL midreset_outputs: busy=%b valid=%b ram_en=%b done=%b required all 0", a_busy, a_blk_valid, a_ram_en, a_done);
    end
    reset = 1'b0;
    clr_a();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (a_dq.size() != 0 || a_aq.size() != 0) begin
      failures++; $display("FAIL midreset_stale: blocks=%0d reads=%0d required 0 and 0", a_dq.size(), a_aq.size());
    end
    start_a(32'd128, 9'd7, t0);
    wait_a_done(1, 20, "midreset");
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (a_dq.size() != 1 || a_aq.size() != 1) begin
      failures++; $display("FAIL midreset_count: blocks=%0d reads=%0d required 1 and 1", a_dq.size(), a_aq.size());
    end
    if (a_dq.size() == 1 && a_aq.size() == 1) begin
      checks++;
      if ({a_aq[0], a_dq[0], a_lq[0], a_cq[0]} !== {9'd7, mem_val(9'd7), 1'b1, 1'b1}) begin
        failures++; $display("FAIL midreset_blk: addr %0d data %h last=%b cmp=%b required addr 7 data %h last=1 cmp=1", a_aq[0], a_dq[0], a_lq[0], a_cq[0], mem_val(9'd7));
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_long();
    test_pad_and_busy_start();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
